// File: rtl/vga_frame_scheduler_if.sv
// Board-side bundle for the frame scheduler: sync, buttons and switches in,
// committed square position, background and status out.
interface vga_frame_scheduler_if;
    logic       iVS;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       sw_black;
    logic       sw_white;
    logic       sw_blue;
    logic       sw_red;
    logic       sw_green;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [2:0] bg_index;
    logic       frame_tick;
    logic       busy;

    // Board / stimulus side.
    modport master (
        output iVS, btn_up, btn_down, btn_left, btn_right,
        output sw_black, sw_white, sw_blue, sw_red, sw_green,
        input  player_x, player_y, bg_index, frame_tick, busy
    );

    // Scheduler side.
    modport slave (
        input  iVS, btn_up, btn_down, btn_left, btn_right,
        input  sw_black, sw_white, sw_blue, sw_red, sw_green,
        output player_x, player_y, bg_index, frame_tick, busy
    );
endinterface

// File: rtl/vga_frame_scheduler.sv
// Frame-synchronous update controller: gathers move requests and background
// switches during the visible frame and commits the new square position and
// background only inside vertical sync, so the pixel pipeline never sees a
// mid-frame change.
module vga_frame_scheduler #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned SQUARE   = 128,
    parameter int unsigned STEP     = 4,
    parameter int unsigned X_INIT   = 256,
    parameter int unsigned Y_INIT   = 176,
    parameter int unsigned MOVE_DIV = 1
) (
    input  logic                  iVGA_CLK,
    input  logic                  reset,
    vga_frame_scheduler_if.slave  bus
);

    localparam int unsigned       FcntW    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [FcntW-1:0]  FcntLast = FcntW'(MOVE_DIV - 1);
    localparam logic signed [10:0] XMax    = 11'(H_ACTIVE - SQUARE);
    localparam logic signed [10:0] YMax    = 11'(V_ACTIVE - SQUARE);
    localparam logic signed [10:0] Step    = 11'(STEP);

    typedef enum logic [1:0] {StIdle, StLatch, StCalc, StCommit} state_e;

    state_e             r_state;
    logic               r_vs_d;
    logic [3:0]         r_sticky;     // {right, left, down, up}
    logic [3:0]         r_req;
    logic [4:0]         r_sw_q;       // {green, red, blue, white, black}
    logic               r_move_en;
    logic [FcntW-1:0]   r_fcnt;
    logic [9:0]         r_nx;
    logic [9:0]         r_ny;
    logic [2:0]         r_nbg;
    logic [9:0]         r_player_x;
    logic [9:0]         r_player_y;
    logic [2:0]         r_bg_index;
    logic               r_frame_tick;
    logic               r_busy;

    logic [3:0]         w_btn;
    logic [4:0]         w_sw;
    logic               w_edge;
    logic signed [10:0] w_x_s;
    logic signed [10:0] w_y_s;
    logic signed [10:0] w_nx_s;
    logic signed [10:0] w_ny_s;
    logic [2:0]         w_nbg;

    assign w_btn  = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
    assign w_sw   = {bus.sw_green, bus.sw_red, bus.sw_blue, bus.sw_white, bus.sw_black};
    assign w_edge = r_vs_d & ~bus.iVS;

    // Next position: opposing requests cancel, single requests step and clamp.
    always_comb begin
        w_x_s  = $signed({1'b0, r_player_x});
        w_y_s  = $signed({1'b0, r_player_y});
        w_nx_s = w_x_s;
        w_ny_s = w_y_s;
        if (r_move_en) begin
            if (r_req[2] && !r_req[3]) begin
                w_nx_s = w_x_s - Step;
                if (w_nx_s < 11'sd0) w_nx_s = 11'sd0;
            end else if (r_req[3] && !r_req[2]) begin
                w_nx_s = w_x_s + Step;
                if (w_nx_s > XMax) w_nx_s = XMax;
            end
            if (r_req[0] && !r_req[1]) begin
                w_ny_s = w_y_s - Step;
                if (w_ny_s < 11'sd0) w_ny_s = 11'sd0;
            end else if (r_req[1] && !r_req[0]) begin
                w_ny_s = w_y_s + Step;
                if (w_ny_s > YMax) w_ny_s = YMax;
            end
        end
    end

    // Background select by fixed priority: black > white > blue > red > green.
    always_comb begin
        w_nbg = 3'd0;
        if (r_sw_q[0])      w_nbg = 3'd1;
        else if (r_sw_q[1]) w_nbg = 3'd2;
        else if (r_sw_q[2]) w_nbg = 3'd3;
        else if (r_sw_q[3]) w_nbg = 3'd4;
        else if (r_sw_q[4]) w_nbg = 3'd5;
    end

    // Update sequencer with sticky request capture and registered outputs.
    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            r_state      <= StIdle;
            r_vs_d       <= 1'b1;
            r_sticky     <= '0;
            r_req        <= '0;
            r_sw_q       <= '0;
            r_move_en    <= 1'b0;
            r_fcnt       <= '0;
            r_nx         <= 10'(X_INIT);
            r_ny         <= 10'(Y_INIT);
            r_nbg        <= 3'd0;
            r_player_x   <= 10'(X_INIT);
            r_player_y   <= 10'(Y_INIT);
            r_bg_index   <= 3'd0;
            r_frame_tick <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_vs_d       <= bus.iVS;
            r_frame_tick <= 1'b0;
            if (r_state != StLatch) r_sticky <= r_sticky | w_btn;
            unique case (r_state)
                StIdle: begin
                    // Edges seen in any other state are deliberately dropped.
                    if (w_edge) begin
                        r_state      <= StLatch;
                        r_frame_tick <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                StLatch: begin
                    r_req  <= r_sticky | w_btn;
                    r_sw_q <= w_sw;
                    if (r_fcnt == FcntLast) begin
                        r_move_en <= 1'b1;
                        r_fcnt    <= '0;
                        r_sticky  <= '0;
                    end else begin
                        // Non-move frame: requests carry over to the next move frame.
                        r_move_en <= 1'b0;
                        r_fcnt    <= r_fcnt + 1'b1;
                        r_sticky  <= r_sticky | w_btn;
                    end
                    r_state <= StCalc;
                end
                StCalc: begin
                    r_nx    <= w_nx_s[9:0];
                    r_ny    <= w_ny_s[9:0];
                    r_nbg   <= w_nbg;
                    r_state <= StCommit;
                end
                StCommit: begin
                    r_player_x <= r_nx;
                    r_player_y <= r_ny;
                    r_bg_index <= r_nbg;
                    r_busy     <= 1'b0;
                    r_state    <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.player_x   = r_player_x;
    assign bus.player_y   = r_player_y;
    assign bus.bg_index   = r_bg_index;
    assign bus.frame_tick = r_frame_tick;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Scoreboard bench for vga_frame_scheduler: one instance with MOVE_DIV=1 and
// one with MOVE_DIV=2 share the same stimulus; expectations are derived from
// per-frame request sets and pushed when each vsync begins.
module tb_vga_frame_scheduler;

    localparam int XMAX  = 640 - 128;
    localparam int YMAX  = 480 - 128;
    localparam int VS_LEN = 8;

    localparam logic [3:0] UP = 4'b0001, DOWN = 4'b0010, LEFT = 4'b0100, RIGHT = 4'b1000;
    localparam logic [4:0] BLACK = 5'b00001, GREEN = 5'b10000;

    typedef struct {
        int ox1, oy1, ox2, oy2, obg;
        int nx1, ny1, nx2, ny2, nbg;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    bit   mon_en = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    exp_t sb[$];

    // Reference state: committed values and requests seen since the last applied move.
    int         mx1, my1, mx2, my2, mbg, frame_cnt;
    logic [3:0] acc1, acc2;

    always #5 clk = ~clk;

    vga_frame_scheduler_if bus1 ();
    vga_frame_scheduler_if bus2 ();

    vga_frame_scheduler u_dut1 (
        .iVGA_CLK (clk),
        .reset    (rst),
        .bus      (bus1.slave)
    );

    vga_frame_scheduler #(
        .MOVE_DIV (2)
    ) u_dut2 (
        .iVGA_CLK (clk),
        .reset    (rst),
        .bus      (bus2.slave)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int step_pos(input int p, input bit dec, input bit inc, input int maxv);
        if (dec && !inc) return (p - 4 < 0) ? 0 : p - 4;
        if (inc && !dec) return (p + 4 > maxv) ? maxv : p + 4;
        return p;
    endfunction

    function automatic int bg_of(input logic [4:0] sw);
        if (sw[0]) return 1;
        if (sw[1]) return 2;
        if (sw[2]) return 3;
        if (sw[3]) return 4;
        if (sw[4]) return 5;
        return 0;
    endfunction

    function automatic logic [3:0] rand_btn();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(1, 15));
        return 4'b0;
    endfunction

    task automatic drive(input logic vs, input logic [3:0] b, input logic [4:0] sw);
        @(negedge clk);
        bus1.iVS = vs;  bus2.iVS = vs;
        {bus1.btn_right, bus1.btn_left, bus1.btn_down, bus1.btn_up} = b;
        {bus2.btn_right, bus2.btn_left, bus2.btn_down, bus2.btn_up} = b;
        {bus1.sw_green, bus1.sw_red, bus1.sw_blue, bus1.sw_white, bus1.sw_black} = sw;
        {bus2.sw_green, bus2.sw_red, bus2.sw_blue, bus2.sw_white, bus2.sw_black} = sw;
    endtask

    // Apply one frame's collected requests to the reference and queue the expectation.
    task automatic model_frame(input logic [4:0] sw);
        exp_t e;
        e.ox1 = mx1; e.oy1 = my1; e.ox2 = mx2; e.oy2 = my2; e.obg = mbg;
        mx1  = step_pos(mx1, acc1[2], acc1[3], XMAX);
        my1  = step_pos(my1, acc1[0], acc1[1], YMAX);
        acc1 = 4'b0;
        if (frame_cnt % 2 == 1) begin
            mx2  = step_pos(mx2, acc2[2], acc2[3], XMAX);
            my2  = step_pos(my2, acc2[0], acc2[1], YMAX);
            acc2 = 4'b0;
        end
        frame_cnt++;
        mbg = bg_of(sw);
        e.nx1 = mx1; e.ny1 = my1; e.nx2 = mx2; e.ny2 = my2; e.nbg = mbg;
        sb.push_back(e);
    endtask

    task automatic run_frame(input int vis_len, input logic [3:0] hold, input logic [3:0] pulse,
                             input bit rnd, input logic [4:0] sw_a, input logic [4:0] sw_b);
        logic [3:0] b0, b1;
        for (int c = 0; c < vis_len; c++) begin
            b0 = hold | ((c == vis_len / 2) ? pulse : 4'b0) | (rnd ? rand_btn() : 4'b0);
            drive(1'b1, b0, (c < vis_len / 2) ? sw_a : sw_b);
            acc1 |= b0;
            acc2 |= b0;
        end
        // The first two vsync cycles both fall inside this frame's request window.
        b0 = hold | (rnd ? rand_btn() : 4'b0);
        b1 = hold | (rnd ? rand_btn() : 4'b0);
        drive(1'b0, b0, sw_b);
        acc1 |= b0 | b1;
        acc2 |= b0 | b1;
        model_frame(sw_b);
        drive(1'b0, b1, sw_b);
        for (int c = 2; c < VS_LEN; c++) begin
            b0 = hold | (rnd ? rand_btn() : 4'b0);
            drive(1'b0, b0, sw_b);
            acc1 |= b0;
            acc2 |= b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x1"}, bus1.player_x, 256);
        check({tag, "_y1"}, bus1.player_y, 176);
        check({tag, "_bg1"}, bus1.bg_index, 0);
        check({tag, "_busy1"}, bus1.busy, 0);
        check({tag, "_tick1"}, bus1.frame_tick, 0);
        check({tag, "_x2"}, bus2.player_x, 256);
        check({tag, "_y2"}, bus2.player_y, 176);
        check({tag, "_busy2"}, bus2.busy, 0);
    endtask

    // Monitor: frame_tick marks a new update; check the whole 4-cycle window against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (bus1.frame_tick) begin
                    if (sb.size() == 0) begin
                        check("tick_without_expect", bus1.frame_tick, 0);
                    end else begin
                        e = sb.pop_front();
                        for (int k = 0; k < 3; k++) begin
                            if (k > 0) begin
                                @(posedge clk);
                                #1;
                            end
                            check("tick1_window", bus1.frame_tick, (k == 0) ? 1 : 0);
                            check("tick2_window", bus2.frame_tick, (k == 0) ? 1 : 0);
                            check("busy1_window", bus1.busy, 1);
                            check("busy2_window", bus2.busy, 1);
                            check("x1_held", bus1.player_x, e.ox1);
                            check("y1_held", bus1.player_y, e.oy1);
                            check("x2_held", bus2.player_x, e.ox2);
                            check("y2_held", bus2.player_y, e.oy2);
                            check("bg_held", bus1.bg_index, e.obg);
                        end
                        @(posedge clk);
                        #1;
                        check("x1_commit", bus1.player_x, e.nx1);
                        check("y1_commit", bus1.player_y, e.ny1);
                        check("x2_commit", bus2.player_x, e.nx2);
                        check("y2_commit", bus2.player_y, e.ny2);
                        check("bg1_commit", bus1.bg_index, e.nbg);
                        check("bg2_commit", bus2.bg_index, e.nbg);
                        check("busy1_done", bus1.busy, 0);
                        check("tick1_done", bus1.frame_tick, 0);
                    end
                end else begin
                    check("busy1_idle", bus1.busy, 0);
                    check("busy2_idle", bus2.busy, 0);
                    check("tick2_idle", bus2.frame_tick, 0);
                end
            end
        end
    end

    initial begin
        mx1 = 256; my1 = 176; mx2 = 256; my2 = 176; mbg = 0; frame_cnt = 0;
        acc1 = 4'b0; acc2 = 4'b0;
        rst = 1'b1;
        drive(1'b1, 4'b0, 5'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Idle with iVS high: nothing may move or tick.
        repeat (100) drive(1'b1, 4'b0, 5'b0);
        check_reset_vals("idle");

        // Single-cycle right pulse mid-frame.
        run_frame(20, 4'b0, RIGHT, 1'b0, 5'b0, 5'b0);
        // Opposing vertical requests cancel, then three down frames.
        run_frame(10, UP | DOWN, 4'b0, 1'b0, 5'b0, 5'b0);
        repeat (3) run_frame(10, DOWN, 4'b0, 1'b0, 5'b0, 5'b0);
        // Background priority and update.
        run_frame(20, 4'b0, 4'b0, 1'b0, 5'b0, GREEN | BLACK);
        run_frame(20, 4'b0, 4'b0, 1'b0, GREEN, GREEN);

        // Drive into each clamp and hold against it.
        repeat (70)  run_frame($urandom_range(6, 12), LEFT, 4'b0, 1'b0, 5'b0, 5'b0);
        repeat (140) run_frame($urandom_range(6, 12), RIGHT, 4'b0, 1'b0, 5'b0, 5'b0);
        repeat (50)  run_frame($urandom_range(6, 12), UP, 4'b0, 1'b0, 5'b0, 5'b0);
        repeat (100) run_frame($urandom_range(6, 12), DOWN, 4'b0, 1'b0, 5'b0, 5'b0);

        // Random traffic.
        repeat (80) run_frame($urandom_range(6, 30), 4'b0, 4'b0, 1'b1,
                              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

        repeat (12) drive(1'b1, 4'b0, 5'b0);
        check("scoreboard_drained", sb.size(), 0);
        mon_en = 1'b0;

        // Reset landing in CALC must discard the update entirely.
        repeat (4) drive(1'b1, 4'b0, 5'b0);
        drive(1'b1, RIGHT, 5'b0);
        drive(1'b1, 4'b0, BLACK);
        drive(1'b0, 4'b0, BLACK);
        drive(1'b0, 4'b0, BLACK);
        @(negedge clk);
        rst = 1'b1;
        bus1.iVS = 1'b1;
        bus2.iVS = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("rst_calc");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) drive(1'b1, 4'b0, 5'b0);
        check_reset_vals("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
